// File: rtl/hpdmc_ddr_txpath_if.sv
// Write-side handshake bundle feeding the DDR transmit FIFO.
// The producer uses the master modport; the transmit path uses slave.
interface hpdmc_ddr_txpath_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_d0;
  logic [WIDTH-1:0] in_d1;

  modport master (
    output in_valid,
    output in_d0,
    output in_d1,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_d0,
    input  in_d1,
    output in_ready
  );
endinterface

// File: rtl/hpdmc_ddr_txpath.sv
// DDR write-data transmit path: word FIFO plus a preamble/burst/postamble
// sequencer that drives the ODDR2 data and strobe banks with registered outputs.
module hpdmc_ddr_txpath #(
  parameter int   WIDTH    = 16,
  parameter int   DEPTH    = 8,
  parameter int   BURST    = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  hpdmc_ddr_txpath_if.slave          wr,
  input  logic                       flush,
  output logic [WIDTH-1:0]           q_d0,
  output logic [WIDTH-1:0]           q_d1,
  output logic                       oe,
  output logic                       dqs_d0,
  output logic                       dqs_d1,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [LW-1:0]    LEVEL_BURST = LW'(BURST);
  localparam logic [LW-1:0]    LEVEL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]    LEVEL_ONE   = LW'(1);
  localparam logic [BW-1:0]    LAST_BEAT   = BW'(BURST - 1);
  localparam logic [PW-1:0]    LAST_PTR    = PW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] IDLE_WORD   = {WIDTH{IDLE_VAL}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_BURST,
    ST_POST
  } txState_e;

  txState_e           r_state;
  logic [LW-1:0]      r_level;
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [BW-1:0]      r_beat;
  logic               r_oe;
  logic               r_dqsD0;
  logic               r_dqsD1;
  logic               r_busy;
  logic [WIDTH-1:0]   r_qD0;
  logic [WIDTH-1:0]   r_qD1;
  logic [2*WIDTH-1:0] r_mem [DEPTH];

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [PW-1:0]      w_wrPtrInc;
  logic [PW-1:0]      w_rdPtrInc;
  logic [LW-1:0]      w_levelNext;
  logic [2*WIDTH-1:0] w_inWord;
  logic [2*WIDTH-1:0] w_headWord;
  logic [2*WIDTH-1:0] w_nextWord;

  assign w_ready     = sys_rst_n & ~flush & (r_level < LEVEL_FULL);
  assign wr.in_ready = w_ready;
  assign w_push      = wr.in_valid & w_ready;
  assign w_pop       = (r_state == ST_BURST);
  assign w_inWord    = {wr.in_d1, wr.in_d0};

  assign w_wrPtrInc = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
  assign w_rdPtrInc = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;

  // Each beat's word is popped at the end of its own cycle, so the word for
  // the following beat sits one slot past the read pointer.
  assign w_headWord = r_mem[r_rdPtr];
  assign w_nextWord = ((r_level == LEVEL_ONE) && w_push) ? w_inWord : r_mem[w_rdPtrInc];

  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop) begin
      w_levelNext = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_levelNext = r_level - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_inWord;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_beat  <= '0;
      r_oe    <= 1'b0;
      r_dqsD0 <= 1'b0;
      r_dqsD1 <= 1'b0;
      r_busy  <= 1'b0;
      r_qD0   <= IDLE_WORD;
      r_qD1   <= IDLE_WORD;
    end else begin
      r_level <= w_levelNext;
      r_dqsD1 <= 1'b0;
      if (w_push) begin
        r_wrPtr <= w_wrPtrInc;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrInc;
      end

      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_level <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
          end else if (r_level >= LEVEL_BURST) begin
            r_state <= ST_PRE;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_PRE: begin
          r_state <= ST_BURST;
          r_beat  <= '0;
          r_dqsD0 <= 1'b1;
          r_qD0   <= w_headWord[WIDTH-1:0];
          r_qD1   <= w_headWord[2*WIDTH-1:WIDTH];
        end

        // Enough data left after the last beat chains straight into the next burst.
        ST_BURST: begin
          if (r_beat == LAST_BEAT) begin
            if (w_levelNext >= LEVEL_BURST) begin
              r_beat <= '0;
              r_qD0  <= w_nextWord[WIDTH-1:0];
              r_qD1  <= w_nextWord[2*WIDTH-1:WIDTH];
            end else begin
              r_state <= ST_POST;
              r_dqsD0 <= 1'b0;
              r_qD0   <= IDLE_WORD;
              r_qD1   <= IDLE_WORD;
            end
          end else begin
            r_beat <= r_beat + 1'b1;
            r_qD0  <= w_nextWord[WIDTH-1:0];
            r_qD1  <= w_nextWord[2*WIDTH-1:WIDTH];
          end
        end

        ST_POST: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q_d0   = r_qD0;
  assign q_d1   = r_qD1;
  assign oe     = r_oe;
  assign dqs_d0 = r_dqsD0;
  assign dqs_d1 = r_dqsD1;
  assign busy   = r_busy;
  assign level  = r_level;

endmodule

// File: tb/tb_hpdmc_ddr_txpath.sv
// Directed bench for hpdmc_ddr_txpath: default build, a deep-burst build
// (DEPTH == BURST) to reach a full FIFO, and an 8-bit single-beat build.
module tb_hpdmc_ddr_txpath;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hpdmc_ddr_txpath_if #(.WIDTH(16)) if0 ();
  logic        flush0;
  logic [15:0] aQd0, aQd1;
  logic        aOe, aDqs0, aDqs1, aBusy;
  logic [3:0]  aLevel;

  hpdmc_ddr_txpath u0 (
    .sys_clk(clk), .sys_rst_n(rstN), .wr(if0), .flush(flush0),
    .q_d0(aQd0), .q_d1(aQd1), .oe(aOe), .dqs_d0(aDqs0), .dqs_d1(aDqs1),
    .busy(aBusy), .level(aLevel)
  );

  hpdmc_ddr_txpath_if #(.WIDTH(8)) if1 ();
  logic        flush1;
  logic [7:0]  bQd0, bQd1;
  logic        bOe, bDqs0, bDqs1, bBusy;
  logic [2:0]  bLevel;

  hpdmc_ddr_txpath #(.WIDTH(8), .DEPTH(4), .BURST(1), .IDLE_VAL(1'b1)) u1 (
    .sys_clk(clk), .sys_rst_n(rstN), .wr(if1), .flush(flush1),
    .q_d0(bQd0), .q_d1(bQd1), .oe(bOe), .dqs_d0(bDqs0), .dqs_d1(bDqs1),
    .busy(bBusy), .level(bLevel)
  );

  hpdmc_ddr_txpath_if #(.WIDTH(16)) if2 ();
  logic        flush2;
  logic [15:0] cQd0, cQd1;
  logic        cOe, cDqs0, cDqs1, cBusy;
  logic [2:0]  cLevel;

  hpdmc_ddr_txpath #(.WIDTH(16), .DEPTH(4), .BURST(4)) u2 (
    .sys_clk(clk), .sys_rst_n(rstN), .wr(if2), .flush(flush2),
    .q_d0(cQd0), .q_d1(cQd1), .oe(cOe), .dqs_d0(cDqs0), .dqs_d1(cDqs1),
    .busy(cBusy), .level(cLevel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    if0.in_valid = 1'b0; if0.in_d0 = '0; if0.in_d1 = '0;
    if1.in_valid = 1'b0; if1.in_d0 = '0; if1.in_d1 = '0;
    if2.in_valid = 1'b0; if2.in_d0 = '0; if2.in_d1 = '0;
    step();
    step();
    checks++;
    if ({aOe, aBusy, aDqs0, aDqs1} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b want 0000", {aOe, aBusy, aDqs0, aDqs1});
    end
    checks++;
    if (aLevel !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_level: got %0d want 0", aLevel);
    end
    checks++;
    if ({aQd0, aQd1} !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_q: got %h want 00000000", {aQd0, aQd1});
    end
    checks++;
    if (if0.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 0", if0.in_ready);
    end
    checks++;
    if ({bQd0, bQd1, bOe, bLevel} !== {16'hFFFF, 1'b0, 3'd0}) begin
      errors++; $display("[TB] FAIL reset_idleval: got %h/%b/%0d want ffff/0/0", {bQd0, bQd1}, bOe, bLevel);
    end
    rstN = 1'b1;
    #1;
    checks++;
    if (if0.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_ready: got %b want 1", if0.in_ready);
    end
  endtask

  task automatic test_single_burst();
    logic [35:0] expV;
    logic        expOe, expDqs;
    int          oeCount;
    oeCount = 0;
    for (int c = 1; c <= 11; c++) begin
      if0.in_valid = (c <= 4);
      if0.in_d0 = 16'(16'h1111 * c);
      if0.in_d1 = 16'(16'hAAAA + 16'h1111 * (c - 1));
      step();
      expOe  = (c >= 5) && (c <= 10);
      expDqs = (c >= 6) && (c <= 9);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? 16'(16'h1111 * (c - 5)) : 16'h0000,
              expDqs ? 16'(16'hAAAA + 16'h1111 * (c - 6)) : 16'h0000};
      if (aOe) oeCount++;
      checks++;
      if ({aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1} !== expV) begin
        errors++; $display("[TB] FAIL single_burst c=%0d: got %h want %h", c, {aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1}, expV);
      end
      if (c == 1) begin
        checks++;
        if (aLevel !== 4'd1) begin
          errors++; $display("[TB] FAIL first_push level: got %0d want 1", aLevel);
        end
      end
    end
    if0.in_valid = 1'b0;
    checks++;
    if (oeCount != 6) begin
      errors++; $display("[TB] FAIL single_oe_cycles: got %0d want 6", oeCount);
    end
    checks++;
    if (aLevel !== 4'd0) begin
      errors++; $display("[TB] FAIL single_level_end: got %0d want 0", aLevel);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] expV;
    logic        expOe, expDqs;
    int          dqsCount;
    dqsCount = 0;
    for (int c = 1; c <= 15; c++) begin
      if0.in_valid = (c <= 8);
      if0.in_d0 = 16'(16'h0100 + c);
      if0.in_d1 = 16'(16'h0200 + c);
      if (c <= 8) begin
        checks++;
        if (if0.in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_ready c=%0d: got %b want 1", c, if0.in_ready);
        end
      end
      step();
      expOe  = (c >= 5) && (c <= 14);
      expDqs = (c >= 6) && (c <= 13);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? 16'(16'h0100 + c - 5) : 16'h0000,
              expDqs ? 16'(16'h0200 + c - 5) : 16'h0000};
      if (aDqs0) dqsCount++;
      checks++;
      if ({aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1} !== expV) begin
        errors++; $display("[TB] FAIL b2b c=%0d: got %h want %h", c, {aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1}, expV);
      end
    end
    if0.in_valid = 1'b0;
    checks++;
    if ((dqsCount != 8) || (aLevel !== 4'd0)) begin
      errors++; $display("[TB] FAIL b2b_totals: got beats=%0d level=%0d want beats=8 level=0", dqsCount, aLevel);
    end
  endtask

  task automatic test_flush_idle();
    logic [35:0] expV;
    logic        expOe, expDqs;
    for (int c = 1; c <= 3; c++) begin
      if0.in_valid = 1'b1;
      if0.in_d0 = 16'(16'h0F00 + c);
      if0.in_d1 = 16'(16'h0E00 + c);
      step();
    end
    checks++;
    if (aLevel !== 4'd3) begin
      errors++; $display("[TB] FAIL flush_pre_level: got %0d want 3", aLevel);
    end
    flush0 = 1'b1;
    if0.in_d0 = 16'hBAD0;
    if0.in_d1 = 16'hBAD1;
    #1;
    checks++;
    if (if0.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_ready: got %b want 0", if0.in_ready);
    end
    step();
    flush0 = 1'b0;
    if0.in_valid = 1'b0;
    checks++;
    if (aLevel !== 4'd0) begin
      errors++; $display("[TB] FAIL flush_level: got %0d want 0", aLevel);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({aOe, aBusy, aLevel} !== 6'd0) begin
        errors++; $display("[TB] FAIL flush_quiet c=%0d: got oe=%b busy=%b level=%0d want 0/0/0", c, aOe, aBusy, aLevel);
      end
    end
    for (int c = 1; c <= 10; c++) begin
      if0.in_valid = (c <= 4);
      if0.in_d0 = 16'(16'h3000 + c);
      if0.in_d1 = 16'(16'h3100 + c);
      step();
      expOe  = (c >= 5) && (c <= 10);
      expDqs = (c >= 6) && (c <= 9);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? 16'(16'h3000 + c - 5) : 16'h0000,
              expDqs ? 16'(16'h3100 + c - 5) : 16'h0000};
      checks++;
      if ({aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1} !== expV) begin
        errors++; $display("[TB] FAIL post_flush_burst c=%0d: got %h want %h", c, {aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1}, expV);
      end
    end
    if0.in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush_in_burst();
    logic [35:0] expV;
    logic        expOe, expDqs;
    for (int c = 1; c <= 11; c++) begin
      if0.in_valid = (c <= 4);
      if0.in_d0 = 16'(16'h4000 + c);
      if0.in_d1 = 16'(16'h4100 + c);
      flush0 = (c == 8);
      step();
      expOe  = (c >= 5) && (c <= 10);
      expDqs = (c >= 6) && (c <= 9);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? 16'(16'h4000 + c - 5) : 16'h0000,
              expDqs ? 16'(16'h4100 + c - 5) : 16'h0000};
      checks++;
      if ({aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1} !== expV) begin
        errors++; $display("[TB] FAIL flush_burst c=%0d: got %h want %h", c, {aOe, aBusy, aDqs0, aDqs1, aQd0, aQd1}, expV);
      end
      if (c == 5 || c == 11) begin
        checks++;
        if (aLevel !== ((c == 5) ? 4'd4 : 4'd0)) begin
          errors++; $display("[TB] FAIL flush_burst_level c=%0d: got %0d want %0d", c, aLevel, (c == 5) ? 4 : 0);
        end
      end
    end
    flush0 = 1'b0;
    if0.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 1; c <= 16; c++) begin
      if0.in_valid = (c <= 4);
      if0.in_d0 = 16'(16'h6000 + c);
      if0.in_d1 = 16'(16'h6100 + c);
      rstN = (c != 9);
      step();
      if (c >= 6 && c <= 8) begin
        checks++;
        if ({aDqs0, aQd0, aQd1} !== {1'b1, 16'(16'h6000 + c - 5), 16'(16'h6100 + c - 5)}) begin
          errors++; $display("[TB] FAIL rst_pre_beats c=%0d: got %b/%h/%h want 1/%h/%h", c, aDqs0, aQd0, aQd1, 16'(16'h6000 + c - 5), 16'(16'h6100 + c - 5));
        end
      end else if (c == 9) begin
        checks++;
        if ({aOe, aBusy, aDqs0, aLevel, aQd0, aQd1, if0.in_ready} !== 40'd0) begin
          errors++; $display("[TB] FAIL rst_abort: got oe=%b busy=%b dqs=%b level=%0d q=%h/%h rdy=%b want all 0", aOe, aBusy, aDqs0, aLevel, aQd0, aQd1, if0.in_ready);
        end
      end else if (c >= 10) begin
        checks++;
        if ({aOe, aDqs0, aLevel} !== 6'd0) begin
          errors++; $display("[TB] FAIL rst_after c=%0d: got oe=%b dqs=%b level=%0d want 0/0/0", c, aOe, aDqs0, aLevel);
        end
      end
    end
    rstN = 1'b1;
    if0.in_valid = 1'b0;
  endtask

  task automatic test_full_fifo();
    logic [35:0] expV;
    logic        expOe, expDqs, accept;
    int          pushed;
    pushed = 0;
    for (int c = 1; c <= 11; c++) begin
      if2.in_valid = (pushed < 5);
      if2.in_d0 = 16'(16'h7001 + pushed);
      if2.in_d1 = 16'(16'h7101 + pushed);
      accept = if2.in_valid && if2.in_ready;
      step();
      if (accept) pushed++;
      expOe  = (c >= 5) && (c <= 10);
      expDqs = (c >= 6) && (c <= 9);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? 16'(16'h7000 + c - 5) : 16'h0000,
              expDqs ? 16'(16'h7100 + c - 5) : 16'h0000};
      checks++;
      if ({cOe, cBusy, cDqs0, cDqs1, cQd0, cQd1} !== expV) begin
        errors++; $display("[TB] FAIL full_seq c=%0d: got %h want %h", c, {cOe, cBusy, cDqs0, cDqs1, cQd0, cQd1}, expV);
      end
      if (c == 4 || c == 6) begin
        checks++;
        if ({cLevel, if2.in_ready} !== {3'd4, 1'b0}) begin
          errors++; $display("[TB] FAIL full_hold c=%0d: got level=%0d rdy=%b want 4/0", c, cLevel, if2.in_ready);
        end
      end else if (c == 7) begin
        checks++;
        if ({cLevel, if2.in_ready} !== {3'd3, 1'b1}) begin
          errors++; $display("[TB] FAIL full_release: got level=%0d rdy=%b want 3/1", cLevel, if2.in_ready);
        end
      end else if (c == 8 || c == 10) begin
        checks++;
        if (cLevel !== ((c == 8) ? 3'd3 : 3'd1)) begin
          errors++; $display("[TB] FAIL full_level c=%0d: got %0d want %0d", c, cLevel, (c == 8) ? 3 : 1);
        end
      end
    end
    if2.in_valid = 1'b0;
    flush2 = 1'b1;
    step();
    flush2 = 1'b0;
    checks++;
    if (cLevel !== 3'd0) begin
      errors++; $display("[TB] FAIL full_flush: got %0d want 0", cLevel);
    end
  endtask

  task automatic test_single_beat();
    logic [19:0] expV;
    logic        expOe, expDqs;
    for (int c = 1; c <= 6; c++) begin
      if1.in_valid = (c == 1);
      if1.in_d0 = 8'h5A;
      if1.in_d1 = 8'hA5;
      step();
      expOe  = (c >= 2) && (c <= 4);
      expDqs = (c == 3);
      expV = {expOe, expOe, expDqs, 1'b0, expDqs ? 16'h5AA5 : 16'hFFFF};
      checks++;
      if ({bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1} !== expV) begin
        errors++; $display("[TB] FAIL single_beat c=%0d: got %h want %h", c, {bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1}, expV);
      end
    end
    for (int c = 1; c <= 6; c++) begin
      if1.in_valid = (c == 1) || (c == 4);
      if1.in_d0 = (c == 1) ? 8'h11 : 8'h22;
      if1.in_d1 = (c == 1) ? 8'h99 : 8'hAA;
      step();
      expOe  = (c >= 2) && (c <= 5);
      expDqs = (c == 3) || (c == 4);
      expV = {expOe, expOe, expDqs, 1'b0,
              (c == 3) ? 16'h1199 : ((c == 4) ? 16'h22AA : 16'hFFFF)};
      checks++;
      if ({bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1} !== expV) begin
        errors++; $display("[TB] FAIL chained_beat c=%0d: got %h want %h", c, {bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1}, expV);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      if1.in_valid = (c <= 4);
      if1.in_d0 = 8'(8'h30 + c);
      if1.in_d1 = 8'(8'h40 + c);
      step();
      expOe  = (c >= 2) && (c <= 7);
      expDqs = (c >= 3) && (c <= 6);
      expV = {expOe, expOe, expDqs, 1'b0,
              expDqs ? {8'(8'h30 + c - 2), 8'(8'h40 + c - 2)} : 16'hFFFF};
      checks++;
      if ({bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1} !== expV) begin
        errors++; $display("[TB] FAIL stream_beat c=%0d: got %h want %h", c, {bOe, bBusy, bDqs0, bDqs1, bQd0, bQd1}, expV);
      end
    end
    if1.in_valid = 1'b0;
    checks++;
    if (bLevel !== 3'd0) begin
      errors++; $display("[TB] FAIL stream_level_end: got %0d want 0", bLevel);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_flush_idle();
    test_flush_in_burst();
    test_reset_mid_burst();
    test_full_fifo();
    test_single_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
